// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter / return-address-stack unit.
//   pc_src_e    : next-PC select encoding driven by control
//   INSTR_BYTES : fixed instruction size, the sequential PC increment
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'b000,
        PC_UNCOND = 3'b001,
        PC_COND   = 3'b010,
        PC_REG    = 3'b011,
        PC_RET    = 3'b100
    } pc_src_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
// The top pointer wraps modulo DEPTH, so pushing onto a full stack silently
// overwrites the oldest entry while the count saturates at DEPTH.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset, clears entries, pointer and count
//   push       in   write push_data above the current top
//   pop        in   discard the top entry (ignored when empty)
//   push_data  in   value to push (link address)
//   top_data   out  current top entry
//   count      out  number of valid entries, 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
// push and pop together replace the top entry in place and keep the count.
module ras_stack #(
    parameter int PC_W  = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [PC_W-1:0]          push_data,
    output logic [PC_W-1:0]          top_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [PC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] top_q;
    logic [PTR_W:0]   cnt_q;
    logic             pop_ok;
    logic [PTR_W-1:0] top_up;
    logic [PTR_W-1:0] top_dn;

    assign top_data = mem[top_q];
    assign count    = cnt_q;
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_MAX);

    // A pop on an empty stack has nothing to discard; with push it degrades to a plain push.
    assign pop_ok = pop & ~empty;
    assign top_up = top_q + PTR_ONE;
    assign top_dn = top_q - PTR_ONE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            case ({push, pop_ok})
                2'b11: begin
                    mem[top_q] <= push_data;
                end
                2'b10: begin
                    mem[top_up] <= push_data;
                    top_q       <= top_up;
                    if (!full) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                2'b01: begin
                    top_q <= top_dn;
                    cnt_q <= cnt_q - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: next-PC generation with a circular return-address stack.
// Optional feature macro: PC_ALIGN_CHECK_EN (word-alignment fault on the selected target).
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-low reset (0 = reset)
//   enable        in   1 = update PC/RAS this edge, 0 = hold all state
//   pc_src        in   next-PC select (pc_src_e; 101..111 behave as sequential)
//   reg_data      in   register branch target, also RET fallback on empty stack
//   br_off        in   unconditional branch byte offset (pre sign-extended)
//   cond_off      in   conditional branch byte offset (pre sign-extended)
//   push          in   push link (pc+4) onto the stack
//   pc            out  current PC
//   pc_plus_4     out  pc+4, combinational link value
//   ras_count     out  valid stack entries
//   ras_empty     out  ras_count == 0
//   ras_full      out  ras_count == RAS_DEPTH
//   ras_underflow out  one-cycle pulse: RET taken with an empty stack
//   misalign      out  sticky alignment fault (0 when the check is not built)
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = 64,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [2:0]                   pc_src,
    input  logic [PC_W-1:0]              reg_data,
    input  logic [PC_W-1:0]              br_off,
    input  logic [PC_W-1:0]              cond_off,
    input  logic                         push,
    output logic [PC_W-1:0]              pc,
    output logic [PC_W-1:0]              pc_plus_4,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_underflow,
    output logic                         misalign
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] seq_tgt;
    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] cond_tgt;
    logic [PC_W-1:0] ras_top;
    logic [PC_W-1:0] target;
    logic            is_ret;
    logic            fault;
    logic            commit;
    logic            underflow_q;

    // All adds wrap modulo 2^PC_W; offsets arrive already in two's complement.
    assign seq_tgt  = pc_q + PC_W'(INSTR_BYTES);
    assign br_tgt   = pc_q + br_off;
    assign cond_tgt = pc_q + cond_off;

    assign is_ret = (pc_src == PC_RET);

    always_comb begin
        target = seq_tgt;
        case (pc_src)
            PC_SEQ:    target = seq_tgt;
            PC_UNCOND: target = br_tgt;
            PC_COND:   target = cond_tgt;
            PC_REG:    target = reg_data;
            PC_RET:    target = ras_empty ? reg_data : ras_top;
            default:   target = seq_tgt;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;

    // Once faulted the PC freezes until reset, so the fault term includes the sticky flag.
    assign fault    = misalign_q | (target[1:0] != 2'b00);
    assign misalign = misalign_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else if (enable && (target[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign fault    = 1'b0;
    assign misalign = 1'b0;
`endif

    assign commit = enable & ~fault;

    ras_stack #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (commit & push),
        .pop       (commit & is_ret),
        .push_data (seq_tgt),
        .top_data  (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q        <= RESET_VEC;
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= commit & is_ret & ras_empty;
            if (commit) begin
                pc_q <= target;
            end
        end
    end

    assign pc            = pc_q;
    assign pc_plus_4     = seq_tgt;
    assign ras_underflow = underflow_q;

endmodule
